// File: rtl/fft_frame_scheduler.sv
// Frame-start pacing for the 8-point MDC FFT. Issues periodic or one-shot starts, gated by
// frames-in-flight credits returned on output tlast. Also keeps a completion count and sticky flags.
module fft_frame_scheduler #(
    parameter int NB_COUNT     = 12,
    parameter int MAX_INFLIGHT = 2,
    parameter int NB_INFLIGHT  = 3,
    parameter int NB_FRAMES    = 16,
    parameter int TIMEOUT      = 1023,
    parameter int NB_TIMEOUT   = 10
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_enable,
    input  logic                   i_single,
    input  logic                   i_clear,
    input  logic [NB_COUNT-1:0]    i_period,
    output logic                   o_gen_valid,
    input  logic                   i_out_tvalid,
    input  logic                   i_out_tready,
    input  logic                   i_out_tlast,
    output logic [NB_INFLIGHT-1:0] o_inflight,
    output logic [NB_FRAMES-1:0]   o_frame_count,
    output logic                   o_busy,
    output logic                   o_timeout,
    output logic                   o_err
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam logic [NB_INFLIGHT-1:0] INFLIGHT_MAX = NB_INFLIGHT'(MAX_INFLIGHT);
    localparam logic [NB_TIMEOUT-1:0]  WD_LIMIT     = NB_TIMEOUT'(TIMEOUT);

    state_t                state;
    logic [NB_COUNT-1:0]   counter;
    logic [NB_COUNT-1:0]   p_reg;
    logic [NB_TIMEOUT-1:0] wd_cnt;
    logic                  beat;
    logic                  done;
    logic                  credit;
    logic                  at_term;
    logic                  issue;
    logic                  wd_run;

    assign beat    = i_out_tvalid & i_out_tready;
    assign done    = beat & i_out_tlast;
    assign credit  = o_inflight < INFLIGHT_MAX;
    assign at_term = counter == p_reg;
    assign wd_run  = ~i_clear & ~beat & (o_inflight != '0);
    assign o_busy  = (state != IDLE) || (o_inflight != '0);

    // A single request is ignored in the same cycle that enable starts periodic mode.
    always_comb begin
        issue = 1'b0;
        case (state)
            IDLE:    issue = ~i_enable & i_single & credit;
            RUN:     issue = i_enable & at_term & credit;
            STALL:   issue = i_enable & credit;
            default: issue = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            counter     <= '0;
            p_reg       <= '0;
            o_gen_valid <= 1'b0;
        end else begin
            o_gen_valid <= issue;
            case (state)
                IDLE: begin
                    if (i_enable) begin
                        p_reg   <= i_period;
                        counter <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (!i_enable) begin
                        counter <= '0;
                        state   <= IDLE;
                    end else if (at_term) begin
                        if (credit) begin
                            counter <= '0;
                        end else begin
                            state <= STALL;
                        end
                    end else begin
                        counter <= counter + NB_COUNT'(1);
                    end
                end
                STALL: begin
                    if (!i_enable) begin
                        counter <= '0;
                        state   <= IDLE;
                    end else if (credit) begin
                        counter <= '0;
                        state   <= RUN;
                    end
                end
                default: begin
                    counter <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Credits, completion count, sticky error and output-side watchdog.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_inflight    <= '0;
            o_frame_count <= '0;
            o_err         <= 1'b0;
            o_timeout     <= 1'b0;
            wd_cnt        <= '0;
        end else begin
            if (issue && !done) begin
                o_inflight <= o_inflight + NB_INFLIGHT'(1);
            end else if (done && !issue && (o_inflight != '0)) begin
                o_inflight <= o_inflight - NB_INFLIGHT'(1);
            end

            if (i_clear) begin
                o_frame_count <= '0;
            end else if (done) begin
                o_frame_count <= o_frame_count + NB_FRAMES'(1);
            end

            if (i_clear) begin
                o_err <= 1'b0;
            end else if (done && (o_inflight == '0)) begin
                o_err <= 1'b1;
            end

            if (!wd_run) begin
                wd_cnt <= '0;
            end else if (wd_cnt != WD_LIMIT) begin
                wd_cnt <= wd_cnt + NB_TIMEOUT'(1);
            end

            // Flag rises on the same edge the count reaches the limit.
            if (i_clear) begin
                o_timeout <= 1'b0;
            end else if (wd_run && (wd_cnt == WD_LIMIT - NB_TIMEOUT'(1))) begin
                o_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed bench for fft_frame_scheduler: expected pulse cycles are queued as stimulus is
// applied and popped by a monitor on each observed frame-start pulse.
`timescale 1ns/1ps
module tb_fft_frame_scheduler;
    localparam int NB_COUNT     = 12;
    localparam int MAX_INFLIGHT = 2;
    localparam int NB_INFLIGHT  = 3;
    localparam int NB_FRAMES    = 16;
    localparam int TIMEOUT      = 1023;
    localparam int NB_TIMEOUT   = 10;

    logic                   i_clk = 1'b0;
    logic                   i_rst_n = 1'b0;
    logic                   i_enable = 1'b0;
    logic                   i_single = 1'b0;
    logic                   i_clear = 1'b0;
    logic [NB_COUNT-1:0]    i_period = '0;
    logic                   i_out_tvalid = 1'b0;
    logic                   i_out_tready = 1'b0;
    logic                   i_out_tlast = 1'b0;
    logic                   o_gen_valid;
    logic [NB_INFLIGHT-1:0] o_inflight;
    logic [NB_FRAMES-1:0]   o_frame_count;
    logic                   o_busy;
    logic                   o_timeout;
    logic                   o_err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int mon_e;
    int exp_q[$];

    fft_frame_scheduler #(
        .NB_COUNT(NB_COUNT), .MAX_INFLIGHT(MAX_INFLIGHT), .NB_INFLIGHT(NB_INFLIGHT),
        .NB_FRAMES(NB_FRAMES), .TIMEOUT(TIMEOUT), .NB_TIMEOUT(NB_TIMEOUT)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_single(i_single),
        .i_clear(i_clear), .i_period(i_period), .o_gen_valid(o_gen_valid),
        .i_out_tvalid(i_out_tvalid), .i_out_tready(i_out_tready), .i_out_tlast(i_out_tlast),
        .o_inflight(o_inflight), .o_frame_count(o_frame_count), .o_busy(o_busy),
        .o_timeout(o_timeout), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic step_to(input int c);
        while (cyc < c) @(negedge i_clk);
    endtask

    // One output beat with tlast, sampled on the next rising edge.
    task automatic beat_done();
        i_out_tvalid = 1'b1;
        i_out_tready = 1'b1;
        i_out_tlast  = 1'b1;
        step(1);
        i_out_tvalid = 1'b0;
        i_out_tready = 1'b0;
        i_out_tlast  = 1'b0;
    endtask

    always @(negedge i_clk) begin
        if (i_rst_n && o_gen_valid) begin
            mon_e = -1;
            if (exp_q.size() != 0) mon_e = exp_q.pop_front();
            check("pulse_cycle", cyc, mon_e);
        end
    end

    initial begin
        #200000;
        $display("FAIL sim_time_limit observed=expired expected=finish");
        $fatal(1, "time limit");
    end

    initial begin
        int k;
        int d;
        step(3);
        check("rst_gen_valid", 32'(o_gen_valid), 0);
        check("rst_inflight", 32'(o_inflight), 0);
        check("rst_frames", 32'(o_frame_count), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_timeout", 32'(o_timeout), 0);
        check("rst_err", 32'(o_err), 0);
        i_rst_n = 1'b1;
        step(2);
        check("idle_busy", 32'(o_busy), 0);

        // Periodic mode, period 500, one completion 10 cycles after each start.
        i_period = 12'd500;
        i_enable = 1'b1;
        k = cyc;
        for (int j = 0; j < 3; j++) exp_q.push_back(k + 502 + 501 * j);
        for (int j = 0; j < 3; j++) begin
            step_to(k + 502 + 501 * j);
            check("periodic_inflight_up", 32'(o_inflight), 1);
            step(9);
            beat_done();
            check("periodic_inflight_down", 32'(o_inflight), 0);
            check("periodic_frames", 32'(o_frame_count), j + 1);
        end
        i_enable = 1'b0;
        step(2);
        check("periodic_all_pulses", exp_q.size(), 0);
        check("periodic_idle_busy", 32'(o_busy), 0);

        // Single shot, then single shot coinciding with a completion.
        i_single = 1'b1;
        exp_q.push_back(cyc + 1);
        step(1);
        i_single = 1'b0;
        check("single_inflight", 32'(o_inflight), 1);
        i_single = 1'b1;
        exp_q.push_back(cyc + 1);
        beat_done();
        i_single = 1'b0;
        check("simul_inflight", 32'(o_inflight), 1);
        check("simul_frames", 32'(o_frame_count), 4);
        beat_done();
        check("simul_drain", 32'(o_inflight), 0);
        check("simul_frames2", 32'(o_frame_count), 5);
        check("simul_no_err", 32'(o_err), 0);

        // Credit stall with period 3 and no completions.
        i_period = 12'd3;
        i_enable = 1'b1;
        k = cyc;
        exp_q.push_back(k + 5);
        exp_q.push_back(k + 9);
        step_to(k + 30);
        check("stall_inflight_max", 32'(o_inflight), 2);
        check("stall_two_pulses", exp_q.size(), 0);
        d = cyc;
        exp_q.push_back(d + 2);
        beat_done();
        check("stall_credit_back", 32'(o_inflight), 1);
        step(1);
        check("stall_refill", 32'(o_inflight), 2);
        check("stall_frames", 32'(o_frame_count), 6);

        // Disable while full, single request dropped, then drain.
        i_enable = 1'b0;
        step(2);
        check("disable_busy_draining", 32'(o_busy), 1);
        i_single = 1'b1;
        step(1);
        i_single = 1'b0;
        step(3);
        check("single_drop_inflight", 32'(o_inflight), 2);
        beat_done();
        check("drain_busy_one_left", 32'(o_busy), 1);
        check("drain_inflight_one", 32'(o_inflight), 1);
        beat_done();
        check("drain_busy_low", 32'(o_busy), 0);
        check("drain_frames", 32'(o_frame_count), 8);

        // Disable exactly when the counter sits at its terminal value.
        i_enable = 1'b1;
        k = cyc;
        exp_q.push_back(k + 5);
        step_to(k + 8);
        i_enable = 1'b0;
        step(6);
        check("disable_first_pulse", exp_q.size(), 0);
        check("disable_inflight", 32'(o_inflight), 1);
        check("disable_busy", 32'(o_busy), 1);
        beat_done();
        check("disable_busy_drained", 32'(o_busy), 0);
        check("disable_frames", 32'(o_frame_count), 9);

        // Completion with nothing in flight.
        beat_done();
        check("err_set", 32'(o_err), 1);
        check("err_frames", 32'(o_frame_count), 10);
        check("err_inflight", 32'(o_inflight), 0);

        // Watchdog with one frame outstanding and no output beats.
        i_single = 1'b1;
        exp_q.push_back(cyc + 1);
        step(1);
        i_single = 1'b0;
        step(1000);
        check("timeout_early", 32'(o_timeout), 0);
        step(40);
        check("timeout_set", 32'(o_timeout), 1);
        i_clear = 1'b1;
        beat_done();
        i_clear = 1'b0;
        check("clear_frames", 32'(o_frame_count), 0);
        check("clear_timeout", 32'(o_timeout), 0);
        check("clear_err", 32'(o_err), 0);
        check("clear_inflight", 32'(o_inflight), 0);
        beat_done();
        check("post_clear_err", 32'(o_err), 1);
        check("post_clear_frames", 32'(o_frame_count), 1);

        // Asynchronous reset during a pulse cycle in RUN.
        i_period = 12'd3;
        i_enable = 1'b1;
        k = cyc;
        exp_q.push_back(k + 5);
        step_to(k + 5);
        #2 i_rst_n = 1'b0;
        #1;
        check("arst_gen_valid", 32'(o_gen_valid), 0);
        check("arst_inflight", 32'(o_inflight), 0);
        check("arst_busy", 32'(o_busy), 0);
        check("arst_frames", 32'(o_frame_count), 0);
        check("arst_err", 32'(o_err), 0);
        i_enable = 1'b0;
        step(2);
        i_rst_n = 1'b1;
        step(3);
        check("arst_release_busy", 32'(o_busy), 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
